// File: rtl/bcd_disp_mux.sv
// Four-digit BCD display mux: snapshot, 7-seg decode, anode scan, frame tick.
// Latency: 1 cycle from a sel change or a load edge to the visible an/sseg.
// Backpressure: none; free-running display sink, load is sampled on any edge.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   en              display enable; low blanks the display and parks the scan on digit 0
//   load            snapshot strobe for d3..d0, dp_in, blank_lz
//   d3..d0          BCD digits (d3 most significant)
//   dp_in           per-digit decimal point, active-high, bit i = digit i
//   blank_lz        blank leading zeros in d3..d1
//   an              anode enables, active-low, bit i = digit i
//   sseg            segments, active-low, {dp,g,f,e,d,c,b,a}
//   frame_tick      one-cycle pulse when the scan wraps from digit 3 to digit 0
module bcd_disp_mux #(
  parameter int DIG_CYCLES = 100000,
  parameter int CW         = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_in,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIG_CYCLES - 1);

  // Segment patterns {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  logic [CW-1:0]   cnt;
  logic [1:0]      sel;
  logic            wrap;

  // Shadow copy of the inputs; the display only ever reads these, so a
  // frame is always drawn from a single snapshot.
  logic [3:0][3:0] sh_dig;
  logic [3:0]      sh_dp;
  logic            sh_blank;

  logic [3:0]      cur_dig;
  logic            cur_blank;
  logic [6:0]      cur_pat;
  logic [3:0]      an_nxt;
  logic [7:0]      sseg_nxt;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] p;
    p = SEG_DASH;
    case (v)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = SEG_DASH;
    endcase
    return p;
  endfunction

  assign wrap = (cnt == CNT_LAST);

  // Refresh counter and digit select. Disabling parks both at zero so that
  // re-enabling gives digit 0 a full dwell period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      sel        <= 2'd0;
      frame_tick <= 1'b0;
    end else if (!en) begin
      cnt        <= '0;
      sel        <= 2'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap && (sel == 2'd3);
      if (wrap) begin
        cnt <= '0;
        sel <= sel + 2'd1;
      end else begin
        cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Snapshot registers; load is honoured regardless of en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_dig   <= '0;
      sh_dp    <= 4'b0000;
      sh_blank <= 1'b0;
    end else if (load) begin
      sh_dig   <= {d3, d2, d1, d0};
      sh_dp    <= dp_in;
      sh_blank <= blank_lz;
    end
  end

  // Leading-zero blanking: a digit is blanked only when it and every more
  // significant digit are zero. Digit 0 always shows.
  always_comb begin
    cur_dig   = sh_dig[sel];
    cur_blank = 1'b0;
    case (sel)
      2'd3:    cur_blank = sh_blank && (sh_dig[3] == 4'd0);
      2'd2:    cur_blank = sh_blank && (sh_dig[3] == 4'd0) && (sh_dig[2] == 4'd0);
      2'd1:    cur_blank = sh_blank && (sh_dig[3] == 4'd0) && (sh_dig[2] == 4'd0)
                           && (sh_dig[1] == 4'd0);
      default: cur_blank = 1'b0;
    endcase
    cur_pat  = cur_blank ? SEG_BLANK : bcd_to_seg(cur_dig);
    // Decimal point stays visible on a blanked digit.
    sseg_nxt = {~sh_dp[sel], cur_pat};
    an_nxt   = ~(4'b0001 << sel);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an   <= 4'b1111;
      sseg <= 8'hFF;
    end else if (!en) begin
      an   <= 4'b1111;
      sseg <= 8'hFF;
    end else begin
      an   <= an_nxt;
      sseg <= sseg_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_disp_mux.sv
module tb_bcd_disp_mux;

  localparam int DIG = 4;
  localparam int FRAME = 4 * DIG;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] d3, d2, d1, d0;
  logic [3:0] dp_in;
  logic       blank_lz;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: snapshot contents and the number of enabled
  // edges seen since the display was last (re)started.
  int         m_dig [4];
  logic [3:0] m_dp;
  logic       m_blz;
  int         m_k;

  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bcd_disp_mux #(.DIG_CYCLES(DIG), .CW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .d3         (d3),
    .d2         (d2),
    .d1         (d1),
    .d0         (d0),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_seg(input int s);
    logic blanked;
    logic [6:0] pat;
    blanked = m_blz && (s > 0);
    for (int j = s; j < 4; j++)
      if (m_dig[j] != 0) blanked = 1'b0;
    if (blanked)          pat = 7'h7F;
    else if (m_dig[s] > 9) pat = 7'h3F;
    else                  pat = seg_tbl[m_dig[s]];
    return {~m_dp[s], pat};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_dp  = 4'b0000;
    m_blz = 1'b0;
    m_k   = 0;
  endtask

  // One clock: predict from pre-edge model state, apply the edge to the
  // model, then compare just after the edge.
  task automatic cyc();
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic       e_ft;
    int         s;
    @(posedge clk);
    if (en) begin
      s     = (m_k / DIG) % 4;
      e_an  = ~(4'b0001 << s);
      e_seg = model_seg(s);
      e_ft  = ((m_k + 1) % FRAME) == 0;
      m_k++;
    end else begin
      e_an  = 4'b1111;
      e_seg = 8'hFF;
      e_ft  = 1'b0;
      m_k   = 0;
    end
    if (load) begin
      m_dig[3] = d3; m_dig[2] = d2; m_dig[1] = d1; m_dig[0] = d0;
      m_dp  = dp_in;
      m_blz = blank_lz;
    end
    #1;
    chk("an", {4'h0, an}, {4'h0, e_an});
    chk("sseg", sseg, e_seg);
    chk("frame_tick", {7'h0, frame_tick}, {7'h0, e_ft});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_digits(input logic [3:0] a3, input logic [3:0] a2,
                            input logic [3:0] a1, input logic [3:0] a0,
                            input logic [3:0] dp, input logic blz);
    d3 = a3; d2 = a2; d1 = a1; d0 = a0; dp_in = dp; blank_lz = blz;
  endtask

  task automatic load_once(input logic [3:0] a3, input logic [3:0] a2,
                           input logic [3:0] a1, input logic [3:0] a0,
                           input logic [3:0] dp, input logic blz);
    set_digits(a3, a2, a1, a0, dp, blz);
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0);
    model_reset();
    #12;
    chk("rst_an", {4'h0, an}, 8'h0F);
    chk("rst_sseg", sseg, 8'hFF);
    chk("rst_ft", {7'h0, frame_tick}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;

    // Free-running scan of the cleared snapshot, through two frame wraps.
    run(2 * FRAME + 4);

    // Asynchronous reset between clock edges.
    #3 reset = 1'b1;
    #1;
    chk("async_rst_an", {4'h0, an}, 8'h0F);
    chk("async_rst_sseg", sseg, 8'hFF);
    chk("async_rst_ft", {7'h0, frame_tick}, 8'h00);
    model_reset();
    #2 reset = 1'b0;
    run(FRAME + 2);

    // Snapshot decode 1,2,3,4.
    load_once(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    run(4 * FRAME + 3);

    // Inputs move without load: display must not follow.
    set_digits(4'd9, 4'd8, 4'd7, 4'd6, 4'b1111, 1'b1);
    run(FRAME);

    // Load on the same edge that advances the digit.
    while ((m_k % DIG) != DIG - 1) cyc();
    load_once(4'd5, 4'd6, 4'd7, 4'd8, 4'b0000, 1'b0);
    run(DIG + 2);

    // Leading-zero blanking.
    load_once(4'd0, 4'd0, 4'd7, 4'd0, 4'b0000, 1'b1);
    run(FRAME + 1);
    load_once(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1);
    run(FRAME + 1);

    // Invalid code with decimal point.
    load_once(4'd5, 4'hC, 4'd1, 4'd0, 4'b0100, 1'b0);
    run(FRAME + 1);

    // Drop enable part-way through digit 2, load while disabled, re-enable.
    while (!(((m_k / DIG) % 4 == 2) && (m_k % DIG == 1))) cyc();
    en = 1'b0;
    run(2);
    load_once(4'd0, 4'd3, 4'd0, 4'd9, 4'b1001, 1'b1);
    run(1);
    en = 1'b1;
    run(FRAME + 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      en   = ($urandom_range(0, 19) != 0);
      load = ($urandom_range(0, 9) == 0);
      d3 = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
      d2 = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
      d1 = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
      d0 = 4'($urandom_range(0, 15));
      dp_in    = 4'($urandom_range(0, 15));
      blank_lz = 1'($urandom_range(0, 1));
      cyc();
    end
    load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
